text_screen_ctrl: RTL



---
 rtl/text_screen_ctrl_pkg.sv | 22 ++
 rtl/edge_detect_rise.sv | 26 ++
 rtl/text_screen_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/text_screen_ctrl_pkg.sv
// Shared definitions for the text overlay sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package text_screen_ctrl_pkg;

  // Screen encodings as seen on screen_state.
  typedef enum logic [1:0] {
    SCREEN_TITLE     = 2'd0,
    SCREEN_PLAYING   = 2'd1,
    SCREEN_GAME_OVER = 2'd2
  } screen_e;

  // Default frame counts, assuming a 60 Hz display.
  localparam int DEF_BLINK_FRAMES     = 30;
  localparam int DEF_TITLE_MIN_FRAMES = 60;
  localparam int DEF_GAME_OVER_FRAMES = 180;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/edge_detect_rise.sv
// Rising-edge detector: registers one level and flags its 0->1 transition.
// Latency: rise is combinational from level, valid in the cycle level first goes high.
// Backpressure: none; a level held high gives exactly one pulse.
//
// Ports:
//   clk   - clock
//   rst   - asynchronous active-high clear of the history register
//   level - clk-synchronous input level
//   rise  - one-cycle pulse, level & ~previous level
module edge_detect_rise (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_q <= 1'b0;
    else     level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/text_screen_ctrl.sv
// Screen sequencer (TITLE / PLAYING / GAME_OVER) driving the text overlay enables.
// Latency: state changes one clock after the qualifying input; outputs decode registered state only.
// Backpressure: none; game_over is a one-cycle pulse, start is edge detected.
//
// Ports:
//   clk, rst       - pixel clock, asynchronous active-high reset
//   vsync          - VGA vsync level; its rising edge is the frame tick
//   start_btn      - debounced start button level
//   game_over      - one-cycle "player lost" pulse from game logic
//   title_en, press_start_en, game_over_en, score_en - overlay enables
//   game_start     - one-cycle pulse on entry to PLAYING
//   screen_state   - current screen encoding
module text_screen_ctrl
  import text_screen_ctrl_pkg::*;
#(
  parameter int BLINK_FRAMES     = DEF_BLINK_FRAMES,
  parameter int TITLE_MIN_FRAMES = DEF_TITLE_MIN_FRAMES,
  parameter int GAME_OVER_FRAMES = DEF_GAME_OVER_FRAMES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic       start_btn,
  input  logic       game_over,
  output logic       title_en,
  output logic       press_start_en,
  output logic       game_over_en,
  output logic       score_en,
  output logic       game_start,
  output logic [1:0] screen_state
);

  localparam int FW = $clog2(max_int(TITLE_MIN_FRAMES, GAME_OVER_FRAMES) + 1);
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  localparam logic [FW-1:0] TITLE_MIN_C  = FW'(TITLE_MIN_FRAMES);
  localparam logic [FW-1:0] GO_LAST_C    = FW'(GAME_OVER_FRAMES - 1);
  localparam logic [BW-1:0] BLINK_LAST_C = BW'(BLINK_FRAMES - 1);

  screen_e       state, state_nxt;
  logic [FW-1:0] frame_cnt;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic          game_start_nxt;
  logic          frame_tick;
  logic          start_rise;

  edge_detect_rise u_vsync_edge (
    .clk   (clk),
    .rst   (rst),
    .level (vsync),
    .rise  (frame_tick)
  );

  edge_detect_rise u_start_edge (
    .clk   (clk),
    .rst   (rst),
    .level (start_btn),
    .rise  (start_rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SCREEN_TITLE;
      frame_cnt   <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
      game_start  <= 1'b0;
    end else begin
      state      <= state_nxt;
      game_start <= game_start_nxt;

      // frame_cnt measures time spent in the current screen only.
      if (state_nxt != state)
        frame_cnt <= '0;
      else if (frame_tick && (frame_cnt != '1))
        frame_cnt <= frame_cnt + FW'(1);

      // Every entry to TITLE (including illegal-state recovery) starts visible.
      if ((state_nxt == SCREEN_TITLE) && (state != SCREEN_TITLE)) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b1;
      end else if ((state == SCREEN_TITLE) && frame_tick) begin
        if (blink_cnt == BLINK_LAST_C) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    game_start_nxt = 1'b0;
    title_en       = 1'b0;
    press_start_en = 1'b0;
    game_over_en   = 1'b0;
    score_en       = 1'b0;
    case (state)
      SCREEN_TITLE: begin
        title_en       = 1'b1;
        press_start_en = blink_phase;
        // Pre-increment frame_cnt is used even if a tick lands on this cycle.
        if (start_rise && (frame_cnt >= TITLE_MIN_C)) begin
          state_nxt      = SCREEN_PLAYING;
          game_start_nxt = 1'b1;
        end
      end
      SCREEN_PLAYING: begin
        score_en = 1'b1;
        if (game_over) state_nxt = SCREEN_GAME_OVER;
      end
      SCREEN_GAME_OVER: begin
        game_over_en = 1'b1;
        score_en     = 1'b1;
        // Leave on the tick that would bring the count to GAME_OVER_FRAMES.
        if (frame_tick && (frame_cnt == GO_LAST_C)) state_nxt = SCREEN_TITLE;
      end
      default: state_nxt = SCREEN_TITLE;
    endcase
  end

  assign screen_state = state;

endmodule
